date_disp_scan: RTL and testbench
=================================

Name: date_disp_scan

Overview:
- Display-side reader for the day/month/year/weekday counter.
- Takes the BCD date digits and the weekday code that the calendar counter produces.
- Drives an 8-digit multiplexed common-anode 7-segment display in the order YYYY MM DD, plus a 7-LED one-hot weekday bar.
- Captures a coherent snapshot once per scan frame, so a date rollover never tears the displayed value. Supports field blinking for the date-set mode.

Parameters:
- SCAN_DIV, 50000: CLK cycles per digit slot; tick period. Legal range ≥2.
- BLINK_DIV, 250: scan ticks per blink half-period. Legal range ≥1.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- YEAR1000  in  4  year thousands BCD
- YEAR100  in  4  year hundreds BCD
- YEAR10  in  4  year tens BCD
- YEAR1  in  4  year units BCD
- MON10  in  4  month tens BCD
- MON1  in  4  month units BCD
- DAY10  in  4  day tens BCD
- DAY1  in  4  day units BCD
- WEEK_DAY  in  3  weekday code 0..6; 7 = invalid
- BLINK_SEL  in  2  0 = none, 1 = year, 2 = month, 3 = day
- AN_N  out  8  digit enables, active-low; bit7 = YEAR1000 … bit0 = DAY1
- SEG_N  out  7  segments {g,f,e,d,c,b,a}, active-low
- WDAY_LED  out  7  one-hot weekday, active-high

Behaviour:
- Reset (RESET=0, asynchronous):
  - prescaler = 0, digit index = 7, blink counter = 0, blink phase = 0, snapshot = all 0.
  - AN_N = 8'hFF, SEG_N = 7'h7F, WDAY_LED = 7'h00.
  - Deassertion is taken synchronously to CLK.
- Prescaler counts 0..SCAN_DIV-1 and wraps. Tick = one-cycle pulse when prescaler = SCAN_DIV-1.
- On each tick edge, the digit index advances 7→0→1→…→7 and wraps.
  - Scan order: index 0 = YEAR1000 (AN bit7), index 7 = DAY1 (AN bit0).
  - Index k drives AN_N bit (7-k) low; all other bits are high.
- Frame snapshot:
  - On the tick edge where the index goes 7→0, all eight digit inputs and WEEK_DAY load into the snapshot registers.
  - Digit 0 of the new frame already shows the freshly captured value.
  - Input changes at any other time are invisible until the next frame start.
- Outputs are registered. AN_N, SEG_N and WDAY_LED all change on the tick edge only, and are stable for SCAN_DIV cycles.
- First tick after reset: the index goes to 0 and the snapshot captures the inputs. Before the first tick the display is dark.
- Segment decode, SEG_N values:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Any BCD value >9 shows a dash: 3F.
  - No leading-zero suppression.
- Blink:
  - The blink counter counts ticks 0..BLINK_DIV-1. Blink phase toggles on the tick where the counter wraps.
  - While the phase is 1 and the current digit belongs to the BLINK_SEL field, SEG_N = 7F and the anode is still driven.
  - Fields: year = idx 0–3, month = idx 4–5, day = idx 6–7.
  - A BLINK_SEL change takes effect on the next tick; it is not frame-latched.
  - BLINK_SEL = 0 never blanks. The phase keeps running regardless of BLINK_SEL.
- WDAY_LED:
  - Updates at frame start from the snapshot. WEEK_DAY = n (0..6) gives bit n = 1.
  - WEEK_DAY = 7 gives all 0.
- Simultaneous events:
  - If frame start coincides with a blink phase toggle, digit 0 uses the new phase.
  - If an input change lands on the capture edge, the value present before that edge is captured.
- Reset mid-frame blanks immediately. The scan restarts per the reset rules with no residual snapshot.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
- Reset held 3 cycles, then released:
  - During reset and the following 3 cycles: AN_N = FF, SEG_N = 7F.
  - At the first tick: AN_N = 7F.
- Inputs 2,0,2,4,1,2,3,1 with WEEK_DAY = 2:
  - Over 8 ticks, AN_N walks 7F, BF, DF, EF, F7, FB, FD, FE.
  - SEG_N = 24, 40, 24, 19, 79, 24, 30, 79.
  - WDAY_LED = 04.
- Tearing:
  - Change DAY1 9→0 and MON1 1→2 at frame index 3.
  - The current frame still shows the old values; the next frame shows the new ones.
- BLINK_SEL = 2:
  - Month digits (AN_N = F7, FB) show SEG_N = 7F in alternating blink half-periods (2 ticks each).
  - Year and day digits are unaffected.
- Invalid values:
  - YEAR10 = A shows SEG_N = 3F.
  - WEEK_DAY = 7 shows WDAY_LED = 00.
- RESET asserted mid-frame:
  - Outputs go dark asynchronously (within the same cycle).
  - After release, the scan restarts at AN_N = 7F.

Source files
------------

// File: rtl/date_disp_scan.sv
// date_disp_scan
// Display-side reader for the calendar counter. Scans an 8-digit multiplexed
// common-anode 7-segment display in the order YYYY MM DD and drives a one-hot
// weekday LED bar. At the start of each scan frame it captures all date digits
// and the weekday together, so a date rollover partway through a frame does
// not change the digits shown in that frame. A selected field can be blinked
// while the date is being set.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset (released synchronously)
//   year1000..day1 BCD date digits from the calendar counter
//   week_day       weekday code 0..6, 7 = invalid
//   blink_sel      0 = none, 1 = year, 2 = month, 3 = day
//   an_n           digit enables, active-low, bit7 = year1000 .. bit0 = day1
//   seg_n          segments {g,f,e,d,c,b,a}, active-low
//   wday_led       one-hot weekday, active-high
module date_disp_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] year1000,
  input  logic [3:0] year100,
  input  logic [3:0] year10,
  input  logic [3:0] year1,
  input  logic [3:0] mon10,
  input  logic [3:0] mon1,
  input  logic [3:0] day10,
  input  logic [3:0] day1,
  input  logic [2:0] week_day,
  input  logic [1:0] blink_sel,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic [6:0] wday_led
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

  // BCD digit to active-low segment pattern; anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Weekday code to one-hot LED pattern; code 7 lights nothing.
  function automatic logic [6:0] wday_decode(input logic [2:0] w);
    logic [6:0] l;
    case (w)
      3'd0:    l = 7'b000_0001;
      3'd1:    l = 7'b000_0010;
      3'd2:    l = 7'b000_0100;
      3'd3:    l = 7'b000_1000;
      3'd4:    l = 7'b001_0000;
      3'd5:    l = 7'b010_0000;
      3'd6:    l = 7'b100_0000;
      default: l = 7'b000_0000;
    endcase
    return l;
  endfunction

  logic [PW-1:0]      prescaler_r;
  logic [2:0]         idx_r;
  logic [BW-1:0]      blink_cnt_r;
  logic               phase_r;
  logic [7:0][3:0]    snap_r;

  logic               tick_s;
  logic               frame_start_s;
  logic               blink_wrap_s;
  logic               phase_nxt_s;
  logic [2:0]         idx_nxt_s;
  logic [7:0][3:0]    digits_s;
  logic [3:0]         digit_s;
  logic               in_field_s;
  logic [7:0]         an_nxt_s;
  logic [6:0]         seg_nxt_s;
  logic [6:0]         wday_nxt_s;

  // Element k of digits_s is scan index k: element 0 = year1000, 7 = day1.
  assign digits_s = {day1, day10, mon1, mon10, year1, year10, year100, year1000};

  // Tick, frame-start and blink-phase bookkeeping, plus the value the next digit slot will show.
  always_comb begin
    tick_s        = (prescaler_r == PRE_MAX);
    idx_nxt_s     = idx_r + 3'd1;
    frame_start_s = tick_s && (idx_r == 3'd7);
    blink_wrap_s  = tick_s && (blink_cnt_r == BLK_MAX);
    // The digit shown by this tick already uses the phase this tick produces.
    phase_nxt_s   = blink_wrap_s ? ~phase_r : phase_r;
    // Digit 0 of a new frame bypasses the snapshot so it shows the value
    // being captured on the same edge.
    digit_s       = frame_start_s ? digits_s[idx_nxt_s] : snap_r[idx_nxt_s];
    case (blink_sel)
      2'd1:    in_field_s = (idx_nxt_s <= 3'd3);
      2'd2:    in_field_s = (idx_nxt_s == 3'd4) || (idx_nxt_s == 3'd5);
      2'd3:    in_field_s = (idx_nxt_s >= 3'd6);
      default: in_field_s = 1'b0;
    endcase
    seg_nxt_s     = (phase_nxt_s && in_field_s) ? 7'h7F : seg_decode(digit_s);
    an_nxt_s      = ~(8'h80 >> idx_nxt_s);
    wday_nxt_s    = wday_decode(week_day);
  end

  // Scan prescaler: counts 0..SCAN_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r <= '0;
    end else if (tick_s) begin
      prescaler_r <= '0;
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
    end
  end

  // Digit index and registered display outputs, updated on ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= 3'd7;
      an_n     <= 8'hFF;
      seg_n    <= 7'h7F;
      wday_led <= 7'h00;
    end else if (tick_s) begin
      idx_r <= idx_nxt_s;
      an_n  <= an_nxt_s;
      seg_n <= seg_nxt_s;
      if (frame_start_s) begin
        wday_led <= wday_nxt_s;
      end else begin
        wday_led <= wday_led;
      end
    end else begin
      idx_r    <= idx_r;
      an_n     <= an_n;
      seg_n    <= seg_n;
      wday_led <= wday_led;
    end
  end

  // Frame snapshot of the date digits, taken on the 7 -> 0 index wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= '0;
    end else if (frame_start_s) begin
      snap_r <= digits_s;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Blink counter (in ticks) and blink phase; runs regardless of blink_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (tick_s) begin
      blink_cnt_r <= blink_wrap_s ? '0 : blink_cnt_r + BW'(1);
      phase_r     <= phase_nxt_s;
    end else begin
      blink_cnt_r <= blink_cnt_r;
      phase_r     <= phase_r;
    end
  end

endmodule

// File: tb/tb_date_disp_scan.sv
// tb_date_disp_scan
// Directed bench for date_disp_scan with SCAN_DIV=4, BLINK_DIV=2. Each step
// advances to the next scan tick and compares an_n, seg_n and wday_led against
// hand-computed values. Blink phase after tick n (n counted from reset) is
// (n/2) mod 2, which fixes which digits are blanked in each frame below.
module tb_date_disp_scan;

  typedef logic [6:0] seg_arr_t [8];

  logic       clk;
  logic       rst_n;
  logic [3:0] year1000, year100, year10, year1;
  logic [3:0] mon10, mon1, day10, day1;
  logic [2:0] week_day;
  logic [1:0] blink_sel;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic [6:0] wday_led;

  int n_checks = 0;
  int n_fails  = 0;

  date_disp_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .year1000(year1000), .year100(year100), .year10(year10), .year1(year1),
    .mon10(mon10), .mon1(mon1), .day10(day10), .day1(day1),
    .week_day(week_day), .blink_sel(blink_sel),
    .an_n(an_n), .seg_n(seg_n), .wday_led(wday_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] a_exp,
                       input logic [6:0] s_exp, input logic [6:0] w_exp);
    n_checks++;
    assert (an_n === a_exp) else begin
      n_fails++;
      $error("FAIL %s an_n observed %h expected %h", tag, an_n, a_exp);
    end
    n_checks++;
    assert (seg_n === s_exp) else begin
      n_fails++;
      $error("FAIL %s seg_n observed %h expected %h", tag, seg_n, s_exp);
    end
    n_checks++;
    assert (wday_led === w_exp) else begin
      n_fails++;
      $error("FAIL %s wday_led observed %h expected %h", tag, wday_led, w_exp);
    end
  endtask

  // Walk one frame of 8 ticks; the first tick is first_edges clocks away,
  // later ticks 4 clocks apart. After slot chg_idx the month/day units change.
  task automatic run_frame(input string tag, input seg_arr_t exp_seg,
                           input logic [6:0] w_exp, input int first_edges,
                           input int chg_idx);
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? first_edges : 4) @(posedge clk);
      #1;
      check($sformatf("%s_idx%0d", tag, i), ~(8'h80 >> i), exp_seg[i], w_exp);
      if (i == chg_idx) begin
        mon1 = 4'd2;
        day1 = 4'd0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    year1000 = 4'd2; year100 = 4'd0; year10 = 4'd2; year1 = 4'd4;
    mon10 = 4'd1; mon1 = 4'd2; day10 = 4'd3; day1 = 4'd1;
    week_day = 3'd2;
    blink_sel = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 8'hFF, 7'h7F, 7'h00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("dark_after_release_%0d", k), 8'hFF, 7'h7F, 7'h00);
    end

    // Frame 1: 2024-12-31, weekday 2.
    run_frame("f1_basic", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h24, 7'h30, 7'h79},
              7'h04, 1, -1);

    // Frame 2: 2024-11-39 captured; at slot 3 the units change to 12 / 30,
    // which must not appear until frame 3.
    mon1 = 4'd1;
    day1 = 4'd9;
    run_frame("f2_tear", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h79, 7'h30, 7'h10},
              7'h04, 4, 3);

    // Frame 3: new values 2024-12-30 visible.
    run_frame("f3_new", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h24, 7'h30, 7'h40},
              7'h04, 4, -1);

    // Frame 4 (ticks 25..32), month blink: tick 30 (idx5) has phase 1.
    blink_sel = 2'd2;
    run_frame("f4_blink_mon", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h7F, 7'h30, 7'h40},
              7'h04, 4, -1);

    // Frame 5 (ticks 33..40), day blink: tick 39 (idx6) has phase 1.
    blink_sel = 2'd3;
    run_frame("f5_blink_day", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h24, 7'h7F, 7'h40},
              7'h04, 4, -1);

    // Frame 6 (ticks 41..48), year blink: ticks 42, 43 (idx1, idx2) have phase 1.
    blink_sel = 2'd1;
    run_frame("f6_blink_year", '{7'h24, 7'h7F, 7'h7F, 7'h19, 7'h79, 7'h24, 7'h30, 7'h40},
              7'h04, 4, -1);

    // Frame 7: invalid year tens digit and invalid weekday.
    blink_sel = 2'd0;
    year10 = 4'hA;
    week_day = 3'd7;
    run_frame("f7_invalid", '{7'h24, 7'h40, 7'h3F, 7'h19, 7'h79, 7'h24, 7'h30, 7'h40},
              7'h00, 4, -1);

    // Start of frame 8, then reset mid-frame between ticks.
    repeat (4) @(posedge clk);
    #1;
    check("f8_idx0", 8'h7F, 7'h24, 7'h00);
    repeat (4) @(posedge clk);
    #1;
    check("f8_idx1", 8'hBF, 7'h40, 7'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_dark", 8'hFF, 7'h7F, 7'h00);
    year10 = 4'd2;
    week_day = 3'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("dark_after_rerelease_%0d", k), 8'hFF, 7'h7F, 7'h00);
    end

    // Frame after re-release restarts at year1000 with a fresh snapshot.
    run_frame("f9_restart", '{7'h24, 7'h40, 7'h24, 7'h19, 7'h79, 7'h24, 7'h30, 7'h40},
              7'h08, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
